// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared opcode constants, instruction-class enum and decoded
//            control bundle for the decode stage.
// Contents : c_op_* opcode constants, cls_e class enum, dec_ctrl_t bundle.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

  // ALU register-register opcodes
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_and  = 4'h3;
  localparam logic [3:0] c_op_or   = 4'h4;
  localparam logic [3:0] c_op_xor  = 4'h7;
  // Immediate opcodes
  localparam logic [3:0] c_op_addi = 4'h5;
  localparam logic [3:0] c_op_lui  = 4'h6;
  localparam logic [3:0] c_op_movi = 4'h8;
  // Memory opcodes: only c_op_st raises is_store, the other two are
  // store-type memory ops that share the LDST class.
  localparam logic [3:0] c_op_st   = 4'h9;
  localparam logic [3:0] c_op_ld   = 4'hA;
  localparam logic [3:0] c_op_stb  = 4'hC;
  localparam logic [3:0] c_op_sth  = 4'hD;
  // Control flow
  localparam logic [3:0] c_op_jmp  = 4'hE;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_IMM  = 3'd2,
    CLS_LDST = 3'd3,
    CLS_LOAD = 3'd4,
    CLS_JUMP = 3'd5
  } cls_e;

  // Width-independent part of the decoded bundle; register indices and the
  // immediate are carried alongside because their widths are parameters.
  typedef struct packed {
    logic [3:0] op;
    cls_e       cls;
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic       reads_rs;   // instruction consumes rs as an operand/base
  } dec_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_fields.sv
`default_nettype none
// ============================================================================
// Module   : decode_fields
// Purpose  : Purely combinational instruction decoder. Splits the word into
//            op / rd / rs / low / byte fields, classifies it and zeroes every
//            field the class does not use.
// Ports    : i_inst  - instruction word
//            o_ctrl  - opcode, class and decode flags
//            o_rd    - destination register index
//            o_rs    - source/base register index
//            o_imm   - sign-extended immediate or displacement
// Revision : 1.0 - initial release
// ============================================================================
module decode_fields
  import decode_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int REG_AW = 4,
  parameter int ADDR_W = 9
) (
  input  logic [INST_W-1:0] i_inst,
  output dec_ctrl_t         o_ctrl,
  output logic [REG_AW-1:0] o_rd,
  output logic [REG_AW-1:0] o_rs,
  output logic [ADDR_W-1:0] o_imm
);

  // Low field L sits below rs; byte field B spans rs and L.
  localparam int c_low_w  = INST_W - 4 - 2*REG_AW;
  localparam int c_byte_w = INST_W - 4 - REG_AW;

  logic [3:0]          w_op;
  logic [REG_AW-1:0]   w_rd;
  logic [REG_AW-1:0]   w_rs;
  logic [c_low_w-1:0]  w_low;
  logic [c_byte_w-1:0] w_byte;
  logic [ADDR_W-1:0]   w_imm_low;
  logic [ADDR_W-1:0]   w_imm_byte;

  assign w_op   = i_inst[INST_W-1 -: 4];
  assign w_rd   = i_inst[INST_W-5 -: REG_AW];
  assign w_rs   = i_inst[INST_W-5-REG_AW -: REG_AW];
  assign w_low  = i_inst[c_low_w-1:0];
  assign w_byte = i_inst[c_byte_w-1:0];

  assign w_imm_low  = ADDR_W'($signed(w_low));
  assign w_imm_byte = ADDR_W'($signed(w_byte));

  always_comb begin
    o_ctrl     = '0;
    o_ctrl.cls = CLS_NOP;
    o_rd       = '0;
    o_rs       = '0;
    o_imm      = '0;
    case (w_op)
      c_op_add, c_op_sub, c_op_and, c_op_or, c_op_xor: begin
        o_ctrl.op       = w_op;
        o_ctrl.cls      = CLS_ALU;
        o_ctrl.reads_rs = 1'b1;
        o_rd            = w_rd;
        o_rs            = w_rs;
      end
      c_op_addi, c_op_lui, c_op_movi: begin
        o_ctrl.op  = w_op;
        o_ctrl.cls = CLS_IMM;
        o_rd       = w_rd;
        o_imm      = w_imm_byte;
      end
      c_op_st, c_op_stb, c_op_sth: begin
        o_ctrl.op       = w_op;
        o_ctrl.cls      = CLS_LDST;
        o_ctrl.is_store = (w_op == c_op_st);
        o_ctrl.reads_rs = 1'b1;
        o_rd            = w_rd;
        o_rs            = w_rs;
        o_imm           = w_imm_low;
      end
      c_op_ld: begin
        o_ctrl.op       = w_op;
        o_ctrl.cls      = CLS_LOAD;
        o_ctrl.is_load  = 1'b1;
        o_ctrl.reads_rs = 1'b1;
        o_rd            = w_rd;
        o_rs            = w_rs;
        o_imm           = w_imm_low;
      end
      c_op_jmp: begin
        o_ctrl.op  = w_op;
        o_ctrl.cls = CLS_JUMP;
        o_imm      = w_imm_byte;
      end
      default: begin
        // Unknown opcode: an all-zero NOP bundle flagged illegal.
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Pipelined instruction decode stage with a single registered
//            output slot, valid/ready handshake on both sides and optional
//            load-use bubble insertion.
// Config   : DECODE_LOAD_USE_STALL_EN - when defined, an instruction that
//            reads the rd of a LOAD held in the output slot is refused for
//            one cycle while a bubble is inserted, and stall_cnt counts the
//            bubbles. When undefined, no stall logic and stall_cnt is 0.
// Ports    : ck, rst_n              - clock, synchronous active-low reset
//            in_valid/in_ready/inst - upstream instruction handshake
//            out_valid/out_ready    - downstream bundle handshake
//            op, cls, rd, rs, imm   - decoded bundle
//            is_load/is_store/illegal - decode flags
//            stall_cnt              - saturating load-use bubble count
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_pkg::*;
#(
  parameter int INST_W = 16,   // must be >= 4 + 2*REG_AW + 1
  parameter int REG_AW = 4,
  parameter int ADDR_W = 9
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [2:0]        cls,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs,
  output logic [ADDR_W-1:0] imm,
  output logic              is_load,
  output logic              is_store,
  output logic              illegal,
  output logic [15:0]       stall_cnt
);

  dec_ctrl_t         w_ctrl;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [ADDR_W-1:0] w_imm;

  logic              r_valid;
  dec_ctrl_t         r_ctrl;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs;
  logic [ADDR_W-1:0] r_imm;

  logic              w_advance;  // output slot is free or being drained
  logic              w_hazard;   // incoming word must wait behind a LOAD
  logic              w_accept;
  logic              w_unused;

  decode_fields #(
    .INST_W (INST_W),
    .REG_AW (REG_AW),
    .ADDR_W (ADDR_W)
  ) u_fields (
    .i_inst (inst),
    .o_ctrl (w_ctrl),
    .o_rd   (w_rd),
    .o_rs   (w_rs),
    .o_imm  (w_imm)
  );

  assign w_advance = !r_valid || out_ready;
  assign in_ready  = rst_n && w_advance && !w_hazard;
  assign w_accept  = in_valid && in_ready;

  // The hazard is re-evaluated each cycle against whatever sits in the
  // output slot, so once the LOAD drains (slot becomes a bubble) the
  // waiting instruction is accepted without any extra hazard state.
`ifdef DECODE_LOAD_USE_STALL_EN
  logic [15:0] r_stall_cnt;

  assign w_hazard = in_valid && r_valid && (r_ctrl.cls == CLS_LOAD)
                    && w_ctrl.reads_rs && (w_rs == r_rd);

  // A bubble is inserted exactly when the held LOAD is consumed while the
  // dependent instruction is being refused.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_hazard && out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign w_hazard  = 1'b0;
  assign stall_cnt = 16'h0000;
`endif

  // reads_rs only feeds the hazard check; it never leaves the block.
  assign w_unused = w_ctrl.reads_rs ^ r_ctrl.reads_rs;

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_rs    <= '0;
      r_imm   <= '0;
    end else if (w_advance) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_ctrl <= w_ctrl;
        r_rd   <= w_rd;
        r_rs   <= w_rs;
        r_imm  <= w_imm;
      end else begin
        // Empty slot or bubble: present an all-zero NOP bundle.
        r_ctrl <= '0;
        r_rd   <= '0;
        r_rs   <= '0;
        r_imm  <= '0;
      end
    end
  end

  assign out_valid = r_valid;
  assign op        = r_ctrl.op;
  assign cls       = r_ctrl.cls;
  assign rd        = r_rd;
  assign rs        = r_rs;
  assign imm       = r_imm;
  assign is_load   = r_ctrl.is_load;
  assign is_store  = r_ctrl.is_store;
  assign illegal   = r_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage: reset values,
//            per-class decode, backpressure hold, load-use bubble (both
//            build flavours) and reset during a stall.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decode_stage;

`ifdef DECODE_LOAD_USE_STALL_EN
  localparam logic [31:0] c_stall_en = 32'd1;
`else
  localparam logic [31:0] c_stall_en = 32'd0;
`endif

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] inst = 16'h0000;

  logic        in_ready;
  logic        out_valid;
  logic [3:0]  op;
  logic [2:0]  cls;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [8:0]  imm;
  logic        is_load;
  logic        is_store;
  logic        illegal;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  decode_stage #(
    .INST_W (16),
    .REG_AW (4),
    .ADDR_W (9)
  ) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .cls       (cls),
    .rd        (rd),
    .rs        (rs),
    .imm       (imm),
    .is_load   (is_load),
    .is_store  (is_store),
    .illegal   (illegal),
    .stall_cnt (stall_cnt)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word at a negedge, confirm it is accepted, and leave the
  // bench at the next negedge with the decoded bundle on the outputs.
  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    inst     = w;
    #1 check("send_ready", 32'(in_ready), 32'd1);
    @(negedge ck);
    in_valid = 1'b0;
    inst     = 16'h0000;
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge ck);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cls",       32'(cls),       32'd0);
    check("rst_rd",        32'(rd),        32'd0);
    check("rst_imm",       32'(imm),       32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    in_valid = 1'b1;
    inst     = 16'h1230;
    #1 check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge ck);
    check("rst_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // ---------------- ALU ----------------
    send(16'h1230);
    check("alu_valid", 32'(out_valid), 32'd1);
    check("alu_cls",   32'(cls),       32'd1);
    check("alu_op",    32'(op),        32'h1);
    check("alu_rd",    32'(rd),        32'd2);
    check("alu_rs",    32'(rs),        32'd3);
    check("alu_imm",   32'(imm),       32'd0);
    @(negedge ck);
    check("alu_drained", 32'(out_valid), 32'd0);

    // ---------------- IMM: rs field nonzero but must read 0 ----------------
    send(16'h54F0);
    check("imm_cls", 32'(cls), 32'd2);
    check("imm_rd",  32'(rd),  32'd4);
    check("imm_rs",  32'(rs),  32'd0);
    check("imm_imm", 32'(imm), 32'h1F0);

    // ---------------- LOAD ----------------
    send(16'hA52F);
    check("ld_cls",      32'(cls),      32'd4);
    check("ld_is_load",  32'(is_load),  32'd1);
    check("ld_is_store", 32'(is_store), 32'd0);
    check("ld_rd",       32'(rd),       32'd5);
    check("ld_rs",       32'(rs),       32'd2);
    check("ld_imm",      32'(imm),      32'h1FF);

    // ---------------- illegal: nothing stale from the LOAD ----------------
    send(16'hF000);
    check("ill_illegal", 32'(illegal), 32'd1);
    check("ill_cls",     32'(cls),     32'd0);
    check("ill_is_load", 32'(is_load), 32'd0);
    check("ill_rd",      32'(rd),      32'd0);
    check("ill_rs",      32'(rs),      32'd0);
    check("ill_imm",     32'(imm),     32'd0);

    // ---------------- store ----------------
    send(16'h9347);
    check("st_cls",      32'(cls),      32'd3);
    check("st_is_store", 32'(is_store), 32'd1);
    check("st_illegal",  32'(illegal),  32'd0);
    check("st_rd",       32'(rd),       32'd3);
    check("st_rs",       32'(rs),       32'd4);
    check("st_imm",      32'(imm),      32'h007);

    // store-type op that is not the plain store
    send(16'hC3A8);
    check("stb_cls",      32'(cls),      32'd3);
    check("stb_is_store", 32'(is_store), 32'd0);
    check("stb_imm",      32'(imm),      32'h1F8);

    // ---------------- JUMP ----------------
    send(16'hE080);
    check("jmp_cls", 32'(cls), 32'd5);
    check("jmp_rd",  32'(rd),  32'd0);
    check("jmp_rs",  32'(rs),  32'd0);
    check("jmp_imm", 32'(imm), 32'h180);
    @(negedge ck);

    // ---------------- backpressure hold ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst      = 16'h2345;
    #1 check("bp_first_ready", 32'(in_ready), 32'd1);
    @(negedge ck);
    inst = 16'h3678;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready),  32'd0);
      check("bp_op",       32'(op),        32'h2);
      check("bp_rd",       32'(rd),        32'd3);
      check("bp_rs",       32'(rs),        32'd4);
      @(negedge ck);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge ck);
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_op",    32'(op),        32'h3);
    check("bp_next_rd",    32'(rd),        32'd6);
    check("bp_next_rs",    32'(rs),        32'd7);
    @(negedge ck);
    check("bp_drained", 32'(out_valid), 32'd0);

    // ---------------- load-use ----------------
    in_valid = 1'b1;
    inst     = 16'hA520;
    @(negedge ck);
    inst = 16'h1150;
    #1 check("lu_in_ready", 32'(in_ready), 32'd1 - c_stall_en);
`ifdef DECODE_LOAD_USE_STALL_EN
    @(negedge ck);
    check("lu_bubble",    32'(out_valid), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    #1 check("lu_retry_ready", 32'(in_ready), 32'd1);
    @(negedge ck);
`else
    @(negedge ck);
`endif
    in_valid = 1'b0;
    check("lu_alu_valid", 32'(out_valid), 32'd1);
    check("lu_alu_op",    32'(op),        32'h1);
    check("lu_alu_rd",    32'(rd),        32'd1);
    check("lu_alu_rs",    32'(rs),        32'd5);
    check("lu_cnt_after", 32'(stall_cnt), c_stall_en);
    @(negedge ck);

    // IMM whose rs field matches the LOAD rd never stalls
    in_valid = 1'b1;
    inst     = 16'hA530;
    @(negedge ck);
    inst = 16'h6152;
    #1 check("nu_in_ready", 32'(in_ready), 32'd1);
    @(negedge ck);
    in_valid = 1'b0;
    check("nu_cls",       32'(cls),       32'd2);
    check("nu_imm",       32'(imm),       32'h052);
    check("nu_stall_cnt", 32'(stall_cnt), c_stall_en);
    @(negedge ck);

    // ---------------- reset during a stall ----------------
    in_valid = 1'b1;
    inst     = 16'hA520;
    @(negedge ck);
    inst  = 16'h1150;
    rst_n = 1'b0;
    @(negedge ck);
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rs_cls",       32'(cls),       32'd0);
    check("rs_rd",        32'(rd),        32'd0);
    #1 check("rs_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge ck);
    check("rs_discarded", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
